// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the chunked magnitude comparator.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // The index register must be at least one bit wide, even when NCHUNK == 1.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_mag_seq.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first differing chunk.
module cmp_mag_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] K_TOP    = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("cmp_mag_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             c_gt, c_eq, c_lt;

  assign a_chunk = a_q[int'(k_q)*CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(k_q)*CHUNK +: CHUNK];

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_chunk),
    .b  (b_chunk),
    .gt (c_gt),
    .eq (c_eq),
    .lt (c_lt)
  );

  // Signed compare becomes unsigned once both sign bits are flipped at capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = signed_mode ? (a ^ MSB_MASK) : a;
          b_d     = signed_mode ? (b ^ MSB_MASK) : b;
          k_d     = K_TOP;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!c_eq) begin
          gt_d    = c_gt;
          eq_d    = 1'b0;
          lt_d    = c_lt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (k_q == '0) begin
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a_gt_b = gt_q;
  assign a_eq_b = eq_q;
  assign a_lt_b = lt_q;

endmodule

// File: tb/tb_cmp_mag_seq.sv
// Scoreboard bench for cmp_mag_seq (16/4): directed vectors with hand-computed flags and latency.
module tb_cmp_mag_seq;

  localparam logic [2:0] GT   = 3'b100;
  localparam logic [2:0] EQ   = 3'b010;
  localparam logic [2:0] LT   = 3'b001;
  localparam logic [2:0] NONE = 3'b000;
  localparam int         MAX_WAIT = 20;

  typedef struct {
    logic [2:0] flags;
    int         lat;
    int         accept;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        a_gt_b;
  logic        a_eq_b;
  logic        a_lt_b;

  int         checks;
  int         failures;
  int         cyc;
  logic [2:0] last_flags;
  exp_t       sb[$];
  exp_t       mon_e;

  cmp_mag_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_gt_b      (a_gt_b),
    .a_eq_b      (a_eq_b),
    .a_lt_b      (a_lt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every done pops one expected result and checks flags and latency.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending compare (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result_flags", int'({a_gt_b, a_eq_b, a_lt_b}), int'(mon_e.flags));
        checkOutput("latency", cyc - mon_e.accept, mon_e.lat);
      end
    end
  end

  // Issue one compare from idle, checking flag hold and busy length while it runs.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                               input logic [2:0] exp_flags, input int lat);
    int busy_cnt;
    @(negedge clk);
    start       = 1'b1;
    a           = av;
    b           = bv;
    signed_mode = sm;
    sb.push_back('{exp_flags, lat, cyc + 1});
    @(negedge clk);
    start    = 1'b0;
    a        = ~av;
    b        = ~bv;
    busy_cnt = 0;
    while (busy && busy_cnt < MAX_WAIT) begin
      busy_cnt++;
      checkOutput("flags_held", int'({a_gt_b, a_eq_b, a_lt_b}), int'(last_flags));
      @(negedge clk);
    end
    checkOutput("busy_cycles", busy_cnt, lat);
    last_flags = exp_flags;
  endtask

  task automatic waitIdle(input string name);
    int guard;
    guard = 0;
    while (busy && guard < MAX_WAIT) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= MAX_WAIT) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, guard);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    last_flags  = NONE;
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_flags", int'({a_gt_b, a_eq_b, a_lt_b}), int'(NONE));
    rst_n = 1'b1;

    applyStimulus(16'h1234, 16'h1234, 1'b0, EQ, 4);
    applyStimulus(16'h8000, 16'h7FFF, 1'b0, GT, 1);
    applyStimulus(16'h8000, 16'h7FFF, 1'b1, LT, 1);
    applyStimulus(16'h0001, 16'hFFFF, 1'b1, GT, 1);
    applyStimulus(16'h12A4, 16'h12B4, 1'b0, LT, 3);
    applyStimulus(16'hFFFF, 16'hFFFE, 1'b1, GT, 4);
    applyStimulus(16'h00F0, 16'h00F0, 1'b1, EQ, 4);

    // start held through busy with changing operands; the done-cycle start is a new request
    @(negedge clk);
    start       = 1'b1;
    signed_mode = 1'b0;
    a           = 16'h0003;
    b           = 16'h0005;
    sb.push_back('{LT, 4, cyc + 1});
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'h0000;
    waitIdle("handshake_first");
    sb.push_back('{GT, 1, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    checkOutput("backtoback_busy", int'(busy), 1);
    waitIdle("handshake_second");
    last_flags = GT;
    repeat (2) @(negedge clk);

    // reset during the second cycle of a 4-cycle compare abandons it
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    checkOutput("midop_busy", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_busy", int'(busy), 0);
    checkOutput("midop_reset_done", int'(done), 0);
    checkOutput("midop_reset_flags", int'({a_gt_b, a_eq_b, a_lt_b}), int'(NONE));
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    last_flags = NONE;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_done", int'(done), 0);
    applyStimulus(16'h0003, 16'h0005, 1'b0, LT, 4);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cmp_mag_seq.md
Name: cmp_mag_seq

Overview:
Parametrised, multi-cycle magnitude comparator; successor to the team's 2-bit combinational comparator. Compares two WIDTH-bit operands CHUNK bits per cycle, MSB-first, with early termination on the first differing chunk and selectable signed/unsigned mode. Start/busy/done handshake and registered, held result flags. Intended for datapath control where a wide single-cycle compare would break timing.

Parameters:
WIDTH, 16, operand width in bits; >= 2; WIDTH % CHUNK == 0 (elaboration error otherwise).
CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request a compare; accepted only when busy=0.
signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
a  in  WIDTH  operand A; sampled with start.
b  in  WIDTH  operand B; sampled with start.
busy  out  1  high while a compare is in progress.
done  out  1  one-cycle pulse when result flags are updated.
a_gt_b  out  1  result: A > B.
a_eq_b  out  1  result: A == B.
a_lt_b  out  1  result: A < B.

Behaviour:
- Reset (rst_n=0, async): state IDLE; busy=0, done=0, a_gt_b=0, a_eq_b=0, a_lt_b=0; operand registers and chunk index cleared. Reset mid-compare abandons it; no done is produced.
- States: IDLE, RUN.
- IDLE: on edge with start=1, capture a, b, signed_mode; set chunk index k=NCHUNK-1 (NCHUNK=WIDTH/CHUNK); busy=1; go RUN. Flags keep their previous values.
- Signed mode: MSB of both captured operands is inverted at capture. The compare is then unsigned on the modified values, so no separate signed path.
- RUN, each cycle, compares chunk k of A and B as unsigned CHUNK-bit values:
  - chunks differ: set gt/lt accordingly, eq=0, done=1, busy=0, go IDLE.
  - chunks equal, k==0: eq=1, gt=0, lt=0, done=1, busy=0, go IDLE.
  - chunks equal, k>0: k<=k-1, stay RUN.
- Latency: start accepted at edge t. The result and done appear at edge t+j, where j = 1 + number of leading equal chunks. Range 1..NCHUNK; for 16/4: 1..4 cycles.
- Exactly one of gt/eq/lt is 1 after the first completed compare; all 0 only after reset.
- Flags are held until the next done. They are not cleared at start.
- start while busy=1 is ignored; operands are not re-sampled. No queueing.
- Back-to-back: done and busy=0 are visible in the same cycle, so start=1 in that cycle is accepted at the next edge.
- done is high for exactly one cycle per accepted start.
- CHUNK==WIDTH degenerates to a registered 1-cycle compare; must still work.

Decomposition:
- Shared package cmp_pkg: state enum (IDLE, RUN); localparam helper for NCHUNK and index width ($clog2(NCHUNK), min 1).
- One sub-module, cmp_chunk: combinational unsigned CHUNK-bit compare (gt/eq/lt). Instantiated once on the muxed chunk slice.

Test Plan:
1. Equal, WIDTH=16/CHUNK=4, unsigned: a=0x1234, b=0x1234 -> done at start+4 cycles, eq=1, gt=0, lt=0; busy high for 4 cycles.
2. MSB chunk differs: a=0x8000, b=0x7FFF, signed_mode=0 -> gt=1 at start+1. Same operands, signed_mode=1 -> lt=1 at start+1.
3. Mid-chunk termination: a=0x12A4, b=0x12B4, unsigned -> lt=1 at start+3; flags from the prior compare held during cycles 1-2.
4. Signed negatives: a=0xFFFF, b=0xFFFE, signed_mode=1 -> gt=1 at start+4. Also a=0x0001, b=0xFFFF signed -> gt=1 at start+1.
5. Handshake: hold start=1 with changing a/b during busy -> result reflects the first-captured operands only. Assert start in the done cycle -> new compare begins next edge; exactly one done per accepted start.
6. Reset mid-op: deassert rst_n at cycle 2 of a 4-cycle compare -> all outputs 0 immediately, no done. After release, a=0x0003, b=0x0005 unsigned -> lt=1 at start+4.
